// File: rtl/axi_lite_cmd_manager_pkg.sv
// Shared types and constants for the AXI-Lite command manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_ctrl_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;
    localparam int AXIL_RESP_W = 2;

    localparam logic [AXIL_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXIL_RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXIL_RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } state_e;

endpackage

// File: rtl/axi_lite_cmd_manager_if.sv
// Command/response handshake plus AXI-Lite manager channels in one bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel; master = manager side, slave = environment side.
interface axi_lite_cmd_manager_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 4,
    parameter int RW = 2
) ();
    // command side
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    // response side
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [RW-1:0] rsp_resp;
    // AXI-Lite manager channels
    logic          M_AXIL_awvalid;
    logic          M_AXIL_awready;
    logic [AW-1:0] M_AXIL_awaddr;
    logic [SW-1:0] M_AXIL_wstrb;
    logic          M_AXIL_wvalid;
    logic          M_AXIL_wready;
    logic [DW-1:0] M_AXIL_wdata;
    logic          M_AXIL_bvalid;
    logic          M_AXIL_bready;
    logic [RW-1:0] M_AXIL_bresp;
    logic          M_AXIL_arvalid;
    logic          M_AXIL_arready;
    logic [AW-1:0] M_AXIL_araddr;
    logic          M_AXIL_rvalid;
    logic          M_AXIL_rready;
    logic [DW-1:0] M_AXIL_rdata;
    logic [RW-1:0] M_AXIL_rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output M_AXIL_awvalid, M_AXIL_awaddr, M_AXIL_wstrb, M_AXIL_wvalid, M_AXIL_wdata,
        output M_AXIL_bready, M_AXIL_arvalid, M_AXIL_araddr, M_AXIL_rready,
        input  M_AXIL_awready, M_AXIL_wready, M_AXIL_bvalid, M_AXIL_bresp,
        input  M_AXIL_arready, M_AXIL_rvalid, M_AXIL_rdata, M_AXIL_rresp
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  M_AXIL_awvalid, M_AXIL_awaddr, M_AXIL_wstrb, M_AXIL_wvalid, M_AXIL_wdata,
        input  M_AXIL_bready, M_AXIL_arvalid, M_AXIL_araddr, M_AXIL_rready,
        output M_AXIL_awready, M_AXIL_wready, M_AXIL_bvalid, M_AXIL_bresp,
        output M_AXIL_arready, M_AXIL_rvalid, M_AXIL_rdata, M_AXIL_rresp
    );

endinterface

// File: rtl/axi_lite_cmd_manager.sv
// Single-outstanding AXI-Lite manager: one command -> one AXI-Lite write or read -> one response.
// Latency: cmd accept T0, AW/W/AR valid T1, response one cycle after the B/R beat is taken.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Optional watchdog: AXIL_TIMEOUT_EN.
module axi_lite_cmd_manager
    import axi_lite_ctrl_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH  = AXIL_ADDR_W,
    parameter int AXI_LITE_DATA_WIDTH  = AXIL_DATA_W,
    parameter int AXI_LITE_WSTRB_WIDTH = AXIL_STRB_W,
    parameter int AXI_LITE_RESP_WIDTH  = AXIL_RESP_W,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_cmd_manager_if.master bus,
    output logic [31:0]            txn_count
);

    // watchdog needs at least one counted cycle before it can fire
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_e                            state_q, state_d;
    logic                              awvalid_q, awvalid_d;
    logic                              wvalid_q, wvalid_d;
    logic                              bready_q, bready_d;
    logic                              arvalid_q, arvalid_d;
    logic                              rready_q, rready_d;
    logic                              rsp_valid_q, rsp_valid_d;
    logic                              write_q, write_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [AXI_LITE_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [AXI_LITE_WSTRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [AXI_LITE_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [AXI_LITE_RESP_WIDTH-1:0]    resp_q, resp_d;
    logic [31:0]                       txn_q, txn_d;
`ifdef AXIL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]                   wd_q, wd_d;
`endif

    // state and all registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            txn_q       <= '0;
`ifdef AXIL_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            txn_q       <= txn_d;
`ifdef AXIL_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // next-state and next-output decode for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        txn_d       = txn_q;
`ifdef AXIL_TIMEOUT_EN
        wd_d        = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    wstrb_d = bus.cmd_wstrb;
                    if (bus.cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                // a low valid inside WR_REQ means that channel already handshook,
                // so the valids double as the per-channel done flags
                if (awvalid_q && bus.M_AXIL_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.M_AXIL_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (bus.M_AXIL_bvalid) begin
                    resp_d      = bus.M_AXIL_bresp;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (bus.M_AXIL_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (bus.M_AXIL_rvalid) begin
                    rdata_d     = bus.M_AXIL_rdata;
                    resp_d      = bus.M_AXIL_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_d       = txn_q + 32'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        // watchdog restarts on every state change; it only fires while stuck
        if ((state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA}) &&
            (state_d == state_q)) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                resp_d      = RESP_DECERR;
                rdata_d     = '0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    assign bus.cmd_ready      = (state_q == ST_IDLE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_write      = write_q;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_resp       = resp_q;
    assign bus.M_AXIL_awvalid = awvalid_q;
    assign bus.M_AXIL_awaddr  = addr_q;
    assign bus.M_AXIL_wvalid  = wvalid_q;
    assign bus.M_AXIL_wdata   = wdata_q;
    assign bus.M_AXIL_wstrb   = wstrb_q;
    assign bus.M_AXIL_bready  = bready_q;
    assign bus.M_AXIL_arvalid = arvalid_q;
    assign bus.M_AXIL_araddr  = addr_q;
    assign bus.M_AXIL_rready  = rready_q;
    assign txn_count          = txn_q;

endmodule

// File: tb/tb_axi_lite_cmd_manager.sv
// Directed bench for axi_lite_cmd_manager with a behavioural subordinate and a transaction-level model.
// Latency: n/a.
// Backpressure: subordinate ready delays and rsp_ready stalls are driven per test.
module tb_axi_lite_cmd_manager;
    import axi_lite_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] txn_count;

    always #5 clk = ~clk;

    axi_lite_cmd_manager_if bus ();

    axi_lite_cmd_manager #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .txn_count (txn_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // ---------------- subordinate configuration and state ----------------
    int          aw_delay = 0, w_delay = 0;
    bit          ar_block = 0, r_hold = 0, timeout_test = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] mem [16];
    int          aw_cnt, w_cnt;
    bit          aw_got, w_got, s_rst, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;

    // per-command observation counters
    int aw_cyc, w_cyc, ar_cyc, b_beats;

    // behavioural AXI-Lite subordinate: decide handshakes before the edge, update after it
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
        bus.M_AXIL_awready = 0; bus.M_AXIL_wready = 0; bus.M_AXIL_bvalid = 0;
        bus.M_AXIL_bresp = 0; bus.M_AXIL_arready = 0; bus.M_AXIL_rvalid = 0;
        bus.M_AXIL_rdata = 0; bus.M_AXIL_rresp = 0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            aw_hs = bus.M_AXIL_awvalid && bus.M_AXIL_awready;
            w_hs  = bus.M_AXIL_wvalid && bus.M_AXIL_wready;
            ar_hs = bus.M_AXIL_arvalid && bus.M_AXIL_arready;
            b_hs  = bus.M_AXIL_bvalid && bus.M_AXIL_bready;
            r_hs  = bus.M_AXIL_rvalid && bus.M_AXIL_rready;
            if (aw_hs) aw_a = bus.M_AXIL_awaddr;
            if (w_hs) begin w_d = bus.M_AXIL_wdata; w_s = bus.M_AXIL_wstrb; end
            if (ar_hs) ar_a = bus.M_AXIL_araddr;
            if (bus.M_AXIL_awvalid && !aw_hs) aw_cnt++;
            if (bus.M_AXIL_wvalid && !w_hs) w_cnt++;
            @(posedge clk);
            #1;
            if (s_rst) begin
                aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
                bus.M_AXIL_awready = 0; bus.M_AXIL_wready = 0; bus.M_AXIL_bvalid = 0;
                bus.M_AXIL_arready = 0; bus.M_AXIL_rvalid = 0; bus.M_AXIL_rdata = 0;
            end else begin
                if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
                if (w_hs) begin w_got = 1; w_cnt = 0; end
                if (b_hs) bus.M_AXIL_bvalid = 0;
                if (aw_got && w_got) begin
                    mem[aw_a[5:2]] = merge(mem[aw_a[5:2]], w_d, w_s);
                    bus.M_AXIL_bvalid = 1;
                    bus.M_AXIL_bresp  = bresp_cfg;
                    aw_got = 0; w_got = 0;
                end
                if (r_hs) begin bus.M_AXIL_rvalid = 0; bus.M_AXIL_rdata = 0; end
                if (ar_hs && !r_hold) begin
                    bus.M_AXIL_rvalid = 1;
                    bus.M_AXIL_rdata  = mem[ar_a[5:2]];
                    bus.M_AXIL_rresp  = rresp_cfg;
                end
                bus.M_AXIL_awready = bus.M_AXIL_awvalid && (aw_cnt >= aw_delay);
                bus.M_AXIL_wready  = bus.M_AXIL_wvalid && (w_cnt >= w_delay);
                bus.M_AXIL_arready = bus.M_AXIL_arvalid && !ar_block;
            end
        end
    end

    // ---------------- transaction-level model and per-cycle compare ----------------
    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] model_mem [16];
    bit          busy;
    int          model_cnt;
    bit          p_aw, p_w, p_ar, p_rsp;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;
    bit          p_write;

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        busy = 0; model_cnt = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; model_cnt = 0; exp_q.delete();
                p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
            end else begin
                if (bus.M_AXIL_awvalid) aw_cyc++;
                if (bus.M_AXIL_wvalid) w_cyc++;
                if (bus.M_AXIL_arvalid) ar_cyc++;
                if (bus.M_AXIL_bvalid && bus.M_AXIL_bready) b_beats++;
                check("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !busy});
                check("txn_count", txn_count, model_cnt);
                if (p_aw) begin
                    check("awvalid_hold", {31'd0, bus.M_AXIL_awvalid}, 32'd1);
                    check("awaddr_stable", bus.M_AXIL_awaddr, p_awaddr);
                end
                if (p_w) begin
                    check("wvalid_hold", {31'd0, bus.M_AXIL_wvalid}, 32'd1);
                    check("wdata_stable", bus.M_AXIL_wdata, p_wdata);
                    check("wstrb_stable", {28'd0, bus.M_AXIL_wstrb}, {28'd0, p_wstrb});
                end
                if (p_ar && !timeout_test) begin
                    check("arvalid_hold", {31'd0, bus.M_AXIL_arvalid}, 32'd1);
                    check("araddr_stable", bus.M_AXIL_araddr, p_araddr);
                end
                if (p_rsp) begin
                    check("rsp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
                    check("rsp_rdata_stable", bus.rsp_rdata, p_rdata);
                    check("rsp_resp_stable", {30'd0, bus.rsp_resp}, {30'd0, p_resp});
                    check("rsp_write_stable", {31'd0, bus.rsp_write}, {31'd0, p_write});
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    busy = 1;
                    e.wr = bus.cmd_write;
                    if (timeout_test) begin
                        e.data = '0; e.resp = RESP_DECERR;
                    end else if (bus.cmd_write) begin
                        e.data = '0; e.resp = bresp_cfg;
                        model_mem[bus.cmd_addr[5:2]] =
                            merge(model_mem[bus.cmd_addr[5:2]], bus.cmd_wdata, bus.cmd_wstrb);
                    end else begin
                        e.data = model_mem[bus.cmd_addr[5:2]]; e.resp = rresp_cfg;
                    end
                    exp_q.push_back(e);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        bound_fail("rsp_without_cmd");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_write", {31'd0, bus.rsp_write}, {31'd0, e.wr});
                        check("rsp_rdata", bus.rsp_rdata, e.data);
                        check("rsp_resp", {30'd0, bus.rsp_resp}, {30'd0, e.resp});
                    end
                    busy = 0;
                    model_cnt++;
                end
                p_aw = bus.M_AXIL_awvalid && !bus.M_AXIL_awready; p_awaddr = bus.M_AXIL_awaddr;
                p_w  = bus.M_AXIL_wvalid && !bus.M_AXIL_wready;
                p_wdata = bus.M_AXIL_wdata; p_wstrb = bus.M_AXIL_wstrb;
                p_ar = bus.M_AXIL_arvalid && !bus.M_AXIL_arready; p_araddr = bus.M_AXIL_araddr;
                p_rsp = bus.rsp_valid && !bus.rsp_ready;
                p_rdata = bus.rsp_rdata; p_resp = bus.rsp_resp; p_write = bus.rsp_write;
            end
        end
    end

    // ---------------- directed command driver ----------------
    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, input bit hold_chk,
                          output bit r_wr, output logic [31:0] r_data, output logic [1:0] r_resp);
        int n;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_beats = 0;
        r_wr = 0; r_data = 'x; r_resp = 'x;
        @(posedge clk); #1;
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a;
        bus.cmd_wdata = d; bus.cmd_wstrb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 50);
        if (!bus.cmd_ready) bound_fail("cmd_accept");
        @(posedge clk); #1;
        bus.cmd_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 200);
        if (!bus.rsp_valid) bound_fail("rsp_wait");
        for (int i = 0; i < hold; i++) begin
            if (hold_chk) begin
                check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("stall_rsp_resp", {30'd0, bus.rsp_resp}, 32'd2);
                check("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        @(negedge clk);
        if (!bus.rsp_valid) bound_fail("rsp_lost");
        r_wr = bus.rsp_write; r_data = bus.rsp_rdata; r_resp = bus.rsp_resp;
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        @(negedge clk);
    endtask

    bit          r_wr;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    initial begin
        int n;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
        bus.cmd_wdata = 0; bus.cmd_wstrb = 0; bus.rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_valids", {28'd0, bus.M_AXIL_awvalid, bus.M_AXIL_wvalid,
                             bus.M_AXIL_arvalid, bus.M_AXIL_bready}, 32'd0);
        check("rst_txn_count", txn_count, 32'd0);

        // zero-wait write then readback
        do_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r_wr, r_data, r_resp);
        check("wr_rsp_write", {31'd0, r_wr}, 32'd1);
        check("wr_rsp_resp", {30'd0, r_resp}, 32'd0);
        check("wr_txn_count", txn_count, 32'd1);
        check("wr_aw_cycles", aw_cyc, 32'd1);
        check("wr_w_cycles", w_cyc, 32'd1);
        check("wr_b_beats", b_beats, 32'd1);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, r_wr, r_data, r_resp);
        check("rd_rdata", r_data, 32'hDEADBEEF);
        check("rd_rsp_resp", {30'd0, r_resp}, 32'd0);
        check("rd_rsp_write", {31'd0, r_wr}, 32'd0);
        check("rd_txn_count", txn_count, 32'd2);
        check("rd_ar_cycles", ar_cyc, 32'd1);

        // wready three cycles late, partial strobe
        w_delay = 3;
        do_cmd(1, 32'h8, 32'h12345678, 4'h3, 0, 0, r_wr, r_data, r_resp);
        w_delay = 0;
        check("lw_aw_cycles", aw_cyc, 32'd1);
        check("lw_w_cycles", w_cyc, 32'd4);
        check("lw_b_beats", b_beats, 32'd1);
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, 0, r_wr, r_data, r_resp);
        check("strb_rdata", r_data, 32'h00005678);

        // error response with stalled consumer
        bresp_cfg = RESP_SLVERR;
        do_cmd(1, 32'hC, 32'hA5A5A5A5, 4'hF, 5, 1, r_wr, r_data, r_resp);
        bresp_cfg = RESP_OKAY;
        check("slverr_resp", {30'd0, r_resp}, 32'd2);
        check("slverr_rdata", r_data, 32'd0);
        rresp_cfg = RESP_SLVERR;
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, r_wr, r_data, r_resp);
        rresp_cfg = RESP_OKAY;
        check("rd_err_resp", {30'd0, r_resp}, 32'd2);
        check("rd_err_rdata", r_data, 32'hDEADBEEF);

        // reset while waiting for read data
        r_hold = 1;
        @(posedge clk); #1;
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h4;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 50);
        @(posedge clk); #1;
        bus.cmd_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.M_AXIL_rready && n < 50);
        if (!bus.M_AXIL_rready) bound_fail("reach_rd_data");
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        r_hold = 0;
        @(negedge clk);
        check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mid_rst_valids", {26'd0, bus.M_AXIL_awvalid, bus.M_AXIL_wvalid, bus.M_AXIL_arvalid,
                                 bus.M_AXIL_bready, bus.M_AXIL_rready, bus.rsp_valid}, 32'd0);
        check("mid_rst_addr", bus.M_AXIL_araddr, 32'd0);
        check("mid_rst_rdata", bus.rsp_rdata, 32'd0);
        check("mid_rst_txn_count", txn_count, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, r_wr, r_data, r_resp);
        check("post_rst_rdata", r_data, 32'hDEADBEEF);
        check("post_rst_txn_count", txn_count, 32'd1);

`ifdef AXIL_TIMEOUT_EN
        // stuck AR channel trips the watchdog
        ar_block = 1; timeout_test = 1;
        do_cmd(0, 32'h10, 32'h0, 4'h0, 0, 0, r_wr, r_data, r_resp);
        ar_block = 0; timeout_test = 0;
        check("to_ar_cycles", ar_cyc, 32'd16);
        check("to_resp", {30'd0, r_resp}, 32'd3);
        check("to_rdata", r_data, 32'd0);
        check("to_arvalid_low", {31'd0, bus.M_AXIL_arvalid}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
